// File: rtl/alu_rs_pkg.sv
// Shared constants, entry types and CDB wakeup helper for the ALU reservation station.
// Used by alu_rs and rs_select.
package alu_rs_pkg;

    localparam int INSIDE_OPCODE_W = 5;
    localparam int ROB_TAG_W       = 4;
    localparam int DATA_W          = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [INSIDE_OPCODE_W-1:0] {
        OP_NOP  = 5'd0,
        OP_ADD  = 5'd1,
        OP_SUB  = 5'd2,
        OP_AND  = 5'd3,
        OP_OR   = 5'd4,
        OP_XOR  = 5'd5,
        OP_SLL  = 5'd6,
        OP_SRL  = 5'd7,
        OP_SRA  = 5'd8,
        OP_SLT  = 5'd9,
        OP_SLTU = 5'd10
    } inside_op_e;

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;
    typedef logic [DATA_W-1:0]    data_t;

    typedef struct packed {
        logic     ready;
        rob_tag_t tag;
        data_t    value;
    } opnd_t;

    typedef struct packed {
        logic                       valid;
        logic [INSIDE_OPCODE_W-1:0] op;
        data_t                      pc;
        data_t                      imm;
        rob_tag_t                   reorder;
        opnd_t                      rs1;
        opnd_t                      rs2;
    } rs_entry_t;

    // The ALU bus takes priority when both buses carry the awaited tag.
    function automatic opnd_t wakeup(input opnd_t cur,
                                     input logic alu_valid, input rob_tag_t alu_tag, input data_t alu_value,
                                     input logic lsb_valid, input rob_tag_t lsb_tag, input data_t lsb_value);
        opnd_t res;
        res = cur;
        if (!cur.ready) begin
            if (alu_valid && alu_tag == cur.tag) begin
                res.ready = TRUE;
                res.value = alu_value;
            end else if (lsb_valid && lsb_tag == cur.tag) begin
                res.ready = TRUE;
                res.value = lsb_value;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Issue selection: picks one issuable entry. With ALU_RS_AGE_SEL_EN the highest
// age rank (oldest) wins, otherwise the lowest index wins.
module rs_select
    import alu_rs_pkg::*;
#(
    parameter int RS_DEPTH = 8,
    parameter int IDX_W    = 3
) (
    input  logic [RS_DEPTH-1:0] valid,
    input  logic [RS_DEPTH-1:0] ready,
`ifdef ALU_RS_AGE_SEL_EN
    input  logic [IDX_W-1:0]    age [RS_DEPTH],
`endif
    output logic [IDX_W-1:0]    grant_idx,
    output logic                grant_valid
);

`ifdef ALU_RS_AGE_SEL_EN
    logic [IDX_W-1:0] best_age;
`endif

    always_comb begin
        grant_idx   = '0;
        grant_valid = FALSE;
`ifdef ALU_RS_AGE_SEL_EN
        best_age    = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (valid[i] && ready[i] && (!grant_valid || age[i] > best_age)) begin
                grant_idx   = IDX_W'(i);
                grant_valid = TRUE;
                best_age    = age[i];
            end
        end
`else
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (valid[i] && ready[i] && !grant_valid) begin
                grant_idx   = IDX_W'(i);
                grant_valid = TRUE;
            end
        end
`endif
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: dispatch, dual-CDB wakeup, single issue per cycle, flush.
// Optional ALU_RS_AGE_SEL_EN selects oldest-first issue instead of lowest-index.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_DEPTH = 8,
    parameter int IDX_W    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       in_dec_valid,
    input  logic [INSIDE_OPCODE_W-1:0] in_dec_op,
    input  logic [DATA_W-1:0]          in_dec_pc,
    input  logic [DATA_W-1:0]          in_dec_imm,
    input  logic [ROB_TAG_W-1:0]       in_dec_reorder,
    input  logic [DATA_W-1:0]          in_dec_value_rs1,
    input  logic [DATA_W-1:0]          in_dec_value_rs2,
    input  logic                       in_dec_ready_rs1,
    input  logic                       in_dec_ready_rs2,
    input  logic [ROB_TAG_W-1:0]       in_dec_tag_rs1,
    input  logic [ROB_TAG_W-1:0]       in_dec_tag_rs2,
    output logic                       out_dec_full,
    input  logic                       in_cdb_alu_valid,
    input  logic [ROB_TAG_W-1:0]       in_cdb_alu_reorder,
    input  logic [DATA_W-1:0]          in_cdb_alu_value,
    input  logic                       in_cdb_lsb_valid,
    input  logic [ROB_TAG_W-1:0]       in_cdb_lsb_reorder,
    input  logic [DATA_W-1:0]          in_cdb_lsb_value,
    input  logic                       in_flush,
    output logic [INSIDE_OPCODE_W-1:0] out_alu_op,
    output logic [DATA_W-1:0]          out_alu_value_rs1,
    output logic [DATA_W-1:0]          out_alu_value_rs2,
    output logic [DATA_W-1:0]          out_alu_value_imm,
    output logic [DATA_W-1:0]          out_alu_pc,
    output logic [ROB_TAG_W-1:0]       out_alu_reorder
);

    rs_entry_t            ent [RS_DEPTH];
    rs_entry_t            new_ent;
    logic [RS_DEPTH-1:0]  valid_vec;
    logic [RS_DEPTH-1:0]  ready_vec;
    logic [IDX_W-1:0]     free_idx;
    logic                 free_found;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_valid;
    logic                 do_disp;

    always_comb begin
        valid_vec  = '0;
        ready_vec  = '0;
        free_idx   = '0;
        free_found = FALSE;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            valid_vec[i] = ent[i].valid;
            ready_vec[i] = ent[i].rs1.ready & ent[i].rs2.ready;
            if (!ent[i].valid && !free_found) begin
                free_idx   = IDX_W'(i);
                free_found = TRUE;
            end
        end
    end

    assign out_dec_full = &valid_vec;
    assign do_disp      = in_dec_valid && !out_dec_full && !in_flush;

    // Incoming operands see this cycle's broadcasts so a result on the bus is not lost.
    always_comb begin
        new_ent         = '0;
        new_ent.valid   = TRUE;
        new_ent.op      = in_dec_op;
        new_ent.pc      = in_dec_pc;
        new_ent.imm     = in_dec_imm;
        new_ent.reorder = in_dec_reorder;
        new_ent.rs1     = wakeup('{in_dec_ready_rs1, in_dec_tag_rs1, in_dec_value_rs1},
                                 in_cdb_alu_valid, in_cdb_alu_reorder, in_cdb_alu_value,
                                 in_cdb_lsb_valid, in_cdb_lsb_reorder, in_cdb_lsb_value);
        new_ent.rs2     = wakeup('{in_dec_ready_rs2, in_dec_tag_rs2, in_dec_value_rs2},
                                 in_cdb_alu_valid, in_cdb_alu_reorder, in_cdb_alu_value,
                                 in_cdb_lsb_valid, in_cdb_lsb_reorder, in_cdb_lsb_value);
    end

`ifdef ALU_RS_AGE_SEL_EN
    // Age is a dense rank among valid entries: 0 is newest, higher is older.
    logic [IDX_W-1:0] age [RS_DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) age[i] <= '0;
        end else if (rdy) begin
            if (in_flush) begin
                for (int unsigned i = 0; i < RS_DEPTH; i++) age[i] <= '0;
            end else begin
                for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                    if (valid_vec[i])
                        age[i] <= age[i] + IDX_W'(do_disp)
                                - IDX_W'(grant_valid && (age[i] > age[grant_idx]));
                end
                if (do_disp) age[free_idx] <= '0;
            end
        end
    end
`endif

    rs_select #(
        .RS_DEPTH (RS_DEPTH),
        .IDX_W    (IDX_W)
    ) u_select (
        .valid       (valid_vec),
        .ready       (ready_vec),
`ifdef ALU_RS_AGE_SEL_EN
        .age         (age),
`endif
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) ent[i] <= '0;
            out_alu_op        <= OP_NOP;
            out_alu_value_rs1 <= '0;
            out_alu_value_rs2 <= '0;
            out_alu_value_imm <= '0;
            out_alu_pc        <= '0;
            out_alu_reorder   <= '0;
        end else if (rdy) begin
            if (in_flush) begin
                for (int unsigned i = 0; i < RS_DEPTH; i++) ent[i].valid <= FALSE;
                out_alu_op      <= OP_NOP;
                out_alu_reorder <= '0;
            end else begin
                for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                    ent[i].rs1 <= wakeup(ent[i].rs1, in_cdb_alu_valid, in_cdb_alu_reorder, in_cdb_alu_value,
                                         in_cdb_lsb_valid, in_cdb_lsb_reorder, in_cdb_lsb_value);
                    ent[i].rs2 <= wakeup(ent[i].rs2, in_cdb_alu_valid, in_cdb_alu_reorder, in_cdb_alu_value,
                                         in_cdb_lsb_valid, in_cdb_lsb_reorder, in_cdb_lsb_value);
                end
                if (grant_valid) begin
                    out_alu_op              <= ent[grant_idx].op;
                    out_alu_value_rs1       <= ent[grant_idx].rs1.value;
                    out_alu_value_rs2       <= ent[grant_idx].rs2.value;
                    out_alu_value_imm       <= ent[grant_idx].imm;
                    out_alu_pc              <= ent[grant_idx].pc;
                    out_alu_reorder         <= ent[grant_idx].reorder;
                    ent[grant_idx].valid    <= FALSE;
                end else begin
                    out_alu_op      <= OP_NOP;
                    out_alu_reorder <= '0;
                end
                if (do_disp) ent[free_idx] <= new_ent;
            end
        end
    end

endmodule
